// File: rtl/mgmt_tx_frame_fifo.sv
// mgmt_tx_frame_fifo: single-clock store-and-forward frame FIFO from the management write port to the PHY TX bus
module mgmt_tx_frame_fifo #(
  parameter int DEPTH     = 4096,
  parameter int HDR_DEPTH = 32,
  parameter int MIN_FRAME = 14,
  parameter int MAX_FRAME = 1518,
  parameter int LEN_WIDTH = 11
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   link_up,
  input  logic                   wr_en,
  input  logic [7:0]             wr_data,
  input  logic                   wr_commit,
  input  logic                   wr_drop,
  output logic [$clog2(DEPTH):0] wr_free,
  input  logic                   tx_ready,
  output logic                   tx_start,
  output logic                   tx_data_valid,
  output logic [7:0]             tx_data,
  output logic [15:0]            drop_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int HW = $clog2(HDR_DEPTH);
  localparam int LW = LEN_WIDTH + 1;
  typedef enum logic [1:0] {IDLE, START, SEND, GAP} state_t;
  state_t state, state_n;
  logic [7:0] ram [DEPTH];
  logic [LEN_WIDTH-1:0] hdr [HDR_DEPTH];
  logic [AW:0] wptr_c, wptr_t, wptr_n, rptr;
  logic [HW:0] hwp, hrp;
  logic [LW-1:0] len, len_n;
  logic [LEN_WIDTH-1:0] rem;
  logic [7:0] ram_q;
  logic bad, bad_n, full, push, commit, accept, reject, hdr_full, hdr_empty, pop, rd_en;
  assign wr_free   = (AW+1)'(DEPTH) - (wptr_t - rptr);
  assign full      = wr_free == '0;
  assign push      = wr_en && !wr_drop && !full && link_up;
  assign wptr_n    = wptr_t + (AW+1)'(push);
  assign len_n     = (push && !(&len)) ? len + LW'(1) : len;
  assign bad_n     = bad || (wr_en && full) || (len_n > LW'(MAX_FRAME));
  assign hdr_full  = (hwp - hrp) == (HW+1)'(HDR_DEPTH);
  assign hdr_empty = hwp == hrp;
  assign commit    = wr_commit && !wr_drop;
  assign accept    = commit && !bad_n && (len_n >= LW'(MIN_FRAME)) && !hdr_full && link_up;
  assign reject    = commit && !accept;
  assign pop       = (state == IDLE) && !hdr_empty && tx_ready && link_up;
  // the first byte is fetched in START so it is on the bus the cycle after tx_start
  assign rd_en     = (state == START) || ((state == SEND) && (rem != LEN_WIDTH'(1)));
  assign tx_data   = tx_data_valid ? ram_q : 8'h00;
  always_comb begin
    state_n       = state;
    tx_start      = 1'b0;
    tx_data_valid = 1'b0;
    case (state)
      IDLE:    state_n = pop ? START : IDLE;
      START: begin
        tx_start = 1'b1;
        state_n  = SEND;
      end
      SEND: begin
        tx_data_valid = 1'b1;
        state_n       = (rem == LEN_WIDTH'(1)) ? GAP : SEND;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (push) ram[wptr_t[AW-1:0]] <= wr_data;
    if (rd_en) ram_q <= ram[rptr[AW-1:0]];
    if (accept) hdr[hwp[HW-1:0]] <= len_n[LEN_WIDTH-1:0];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wptr_c     <= '0;
      wptr_t     <= '0;
      rptr       <= '0;
      hwp        <= '0;
      hrp        <= '0;
      len        <= '0;
      bad        <= 1'b0;
      rem        <= '0;
      drop_count <= '0;
    end else begin
      if (reject && !(&drop_count)) drop_count <= drop_count + 16'd1;
      if (!link_up) begin
        state  <= IDLE;
        wptr_c <= rptr;
        wptr_t <= rptr;
        hrp    <= hwp;
        len    <= '0;
        bad    <= 1'b0;
      end else begin
        state <= state_n;
        if (pop) begin
          rem <= hdr[hrp[HW-1:0]];
          hrp <= hrp + (HW+1)'(1);
        end else if (state == SEND) rem <= rem - LEN_WIDTH'(1);
        if (rd_en) rptr <= rptr + (AW+1)'(1);
        if (wr_drop || reject) begin
          wptr_t <= wptr_c;
          len    <= '0;
          bad    <= 1'b0;
        end else begin
          wptr_t <= wptr_n;
          len    <= accept ? '0 : len_n;
          bad    <= accept ? 1'b0 : bad_n;
          if (accept) begin
            wptr_c <= wptr_n;
            hwp    <= hwp + (HW+1)'(1);
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_mgmt_tx_frame_fifo.sv
// tb_mgmt_tx_frame_fifo: randomized scenario bench with a frame-queue reference model
module tb_mgmt_tx_frame_fifo;
  localparam int DEPTH = 4096;
  localparam int HDR_DEPTH = 32;
  localparam int MIN_FRAME = 14;
  localparam int MAX_FRAME = 1518;
  logic clk = 1'b0, rst = 1'b1, link_up = 1'b1, wr_en = 1'b0, wr_commit = 1'b0, wr_drop = 1'b0, tx_ready = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic [12:0] wr_free;
  logic tx_start, tx_data_valid;
  logic [7:0] tx_data;
  logic [15:0] drop_count;
  int n_cmp = 0, n_bad = 0, exp_drops = 0, cyc = 0;
  bit rnd_ready = 1'b0;
  logic [7:0] frame[$], expb[$], rxb[$], a_frame[$];
  int expl[$], rxl[$], rxs[$], rxe[$], rxf[$];
  int cur = 0, last_v = 0;
  bit in_fr = 1'b0;

  mgmt_tx_frame_fifo dut (
    .clk(clk), .rst(rst), .link_up(link_up), .wr_en(wr_en), .wr_data(wr_data),
    .wr_commit(wr_commit), .wr_drop(wr_drop), .wr_free(wr_free), .tx_ready(tx_ready),
    .tx_start(tx_start), .tx_data_valid(tx_data_valid), .tx_data(tx_data), .drop_count(drop_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tx_start) begin
      in_fr = 1'b1;
      cur = 0;
      rxs.push_back(cyc);
    end else if (tx_data_valid) begin
      if (cur == 0) rxf.push_back(cyc);
      rxb.push_back(tx_data);
      cur++;
      last_v = cyc;
    end else if (in_fr) begin
      rxl.push_back(cur);
      rxe.push_back(last_v);
      in_fr = 1'b0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_ready) tx_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic drive_bytes(input int n, input bit seq, input bit commit_last);
    logic [7:0] b;
    frame.delete();
    for (int i = 0; i < n; i++) begin
      b = seq ? 8'(i) : 8'($urandom);
      frame.push_back(b);
      wr_en = 1'b1;
      wr_data = b;
      wr_commit = commit_last && (i == n - 1);
      tick();
    end
    wr_en = 1'b0;
    wr_commit = 1'b0;
  endtask

  task automatic pulse(input bit c, input bit d, input bit e);
    wr_commit = c;
    wr_drop = d;
    wr_en = e;
    tick();
    wr_commit = 1'b0;
    wr_drop = 1'b0;
    wr_en = 1'b0;
  endtask

  // reference rule: a committed frame survives only if it fits, has a legal length and the link is up
  task automatic model_commit(input int n, input bit fits);
    if (fits && n >= MIN_FRAME && n <= MAX_FRAME && link_up) begin
      foreach (frame[i]) expb.push_back(frame[i]);
      expl.push_back(n);
    end else exp_drops++;
  endtask

  task automatic wait_rx(input int n, input int lim, output bit ok);
    int k = 0;
    while (rxl.size() < n && k < lim) begin
      tick();
      k++;
    end
    ok = rxl.size() >= n;
    repeat (8) tick();
  endtask

  function automatic int frames_diff();
    int e = 0;
    if (rxl.size() != expl.size()) e++;
    else foreach (rxl[i]) if (rxl[i] != expl[i]) e++;
    if (rxb.size() != expb.size()) e++;
    else foreach (rxb[i]) if (rxb[i] != expb[i]) e++;
    return e;
  endfunction

  task automatic clear_q();
    rxb.delete(); rxl.delete(); rxs.delete(); rxe.delete(); rxf.delete();
    expb.delete(); expl.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_cmp++; if (tx_start !== 1'b0) begin n_bad++; $display("FAIL reset tx_start: got %b want 0", tx_start); end
    n_cmp++; if (tx_data_valid !== 1'b0) begin n_bad++; $display("FAIL reset tx_data_valid: got %b want 0", tx_data_valid); end
    n_cmp++; if (tx_data !== 8'h00) begin n_bad++; $display("FAIL reset tx_data: got %h want 00", tx_data); end
    n_cmp++; if (drop_count !== 16'd0) begin n_bad++; $display("FAIL reset drop_count: got %0d want 0", drop_count); end
    n_cmp++; if (wr_free !== 13'(DEPTH)) begin n_bad++; $display("FAIL reset wr_free: got %0d want %0d", wr_free, DEPTH); end
    rst = 1'b0;
    exp_drops = 0;
    tick();
  endtask

  task automatic test_single();
    bit ok;
    int d;
    tx_ready = 1'b1;
    drive_bytes(64, 1'b1, 1'b1);
    model_commit(64, 1'b1);
    wait_rx(1, 300, ok);
    d = frames_diff();
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL single timeout: got %0d frames want 1", rxl.size()); end
    n_cmp++; if (d !== 0) begin n_bad++; $display("FAIL single frames: got %0d frames/%0d bytes want %0d/%0d", rxl.size(), rxb.size(), expl.size(), expb.size()); end
    n_cmp++; if (rxs.size() !== 1) begin n_bad++; $display("FAIL single tx_start count: got %0d want 1", rxs.size()); end
    n_cmp++; if (rxf[0] - rxs[0] !== 1) begin n_bad++; $display("FAIL single first byte latency: got %0d want 1", rxf[0] - rxs[0]); end
    n_cmp++; if (drop_count !== 16'(exp_drops)) begin n_bad++; $display("FAIL single drop_count: got %0d want %0d", drop_count, exp_drops); end
    n_cmp++; if (wr_free !== 13'(DEPTH)) begin n_bad++; $display("FAIL single wr_free: got %0d want %0d", wr_free, DEPTH); end
    clear_q();
  endtask

  task automatic test_back_to_back();
    bit ok;
    int d;
    tx_ready = 1'b0;
    for (int f = 0; f < 3; f++) begin
      drive_bytes(60, 1'b0, 1'b1);
      model_commit(60, 1'b1);
    end
    tick();
    tx_ready = 1'b1;
    wait_rx(3, 600, ok);
    d = frames_diff();
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL b2b timeout: got %0d frames want 3", rxl.size()); end
    n_cmp++; if (d !== 0) begin n_bad++; $display("FAIL b2b frames: got %0d frames/%0d bytes want %0d/%0d", rxl.size(), rxb.size(), expl.size(), expb.size()); end
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (rxs[k+1] - rxe[k] !== 3) begin n_bad++; $display("FAIL b2b gap %0d: got %0d cycles want 3", k, rxs[k+1] - rxe[k]); end
    end
    n_cmp++; if (wr_free !== 13'(DEPTH)) begin n_bad++; $display("FAIL b2b wr_free: got %0d want %0d", wr_free, DEPTH); end
    clear_q();
  endtask

  task automatic test_overflow();
    bit ok;
    int d;
    tx_ready = 1'b1;
    drive_bytes(DEPTH + 10, 1'b0, 1'b0);
    n_cmp++; if (wr_free !== 13'd0) begin n_bad++; $display("FAIL overflow full wr_free: got %0d want 0", wr_free); end
    pulse(1'b1, 1'b0, 1'b0);
    model_commit(DEPTH + 10, 1'b0);
    repeat (5) tick();
    n_cmp++; if (drop_count !== 16'(exp_drops)) begin n_bad++; $display("FAIL overflow drop_count: got %0d want %0d", drop_count, exp_drops); end
    n_cmp++; if (wr_free !== 13'(DEPTH)) begin n_bad++; $display("FAIL overflow wr_free: got %0d want %0d", wr_free, DEPTH); end
    n_cmp++; if (rxl.size() !== 0) begin n_bad++; $display("FAIL overflow output: got %0d frames want 0", rxl.size()); end
    drive_bytes(60, 1'b0, 1'b1);
    model_commit(60, 1'b1);
    wait_rx(1, 300, ok);
    d = frames_diff();
    n_cmp++; if (!ok || d !== 0) begin n_bad++; $display("FAIL overflow follow frame: got %0d frames/%0d bytes want %0d/%0d", rxl.size(), rxb.size(), expl.size(), expb.size()); end
    clear_q();
  endtask

  task automatic test_filter();
    bit ok;
    int d;
    tx_ready = 1'b1;
    drive_bytes(10, 1'b0, 1'b1);
    model_commit(10, 1'b1);
    drive_bytes(MAX_FRAME + 1, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    model_commit(MAX_FRAME + 1, 1'b1);
    drive_bytes(20, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    drive_bytes(20, 1'b0, 1'b0);
    pulse(1'b1, 1'b1, 1'b1);
    repeat (5) tick();
    n_cmp++; if (drop_count !== 16'(exp_drops)) begin n_bad++; $display("FAIL filter drop_count: got %0d want %0d", drop_count, exp_drops); end
    n_cmp++; if (wr_free !== 13'(DEPTH)) begin n_bad++; $display("FAIL filter wr_free: got %0d want %0d", wr_free, DEPTH); end
    n_cmp++; if (rxl.size() !== 0) begin n_bad++; $display("FAIL filter output: got %0d frames want 0", rxl.size()); end
    drive_bytes(MIN_FRAME, 1'b0, 1'b1);
    model_commit(MIN_FRAME, 1'b1);
    drive_bytes(MAX_FRAME, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    model_commit(MAX_FRAME, 1'b1);
    wait_rx(2, 4000, ok);
    d = frames_diff();
    n_cmp++; if (!ok || d !== 0) begin n_bad++; $display("FAIL filter min/max frames: got %0d frames/%0d bytes want %0d/%0d", rxl.size(), rxb.size(), expl.size(), expb.size()); end
    n_cmp++; if (drop_count !== 16'(exp_drops)) begin n_bad++; $display("FAIL filter min/max drop_count: got %0d want %0d", drop_count, exp_drops); end
    clear_q();
  endtask

  task automatic test_hdr_full();
    bit ok;
    int d;
    tx_ready = 1'b0;
    for (int i = 0; i <= HDR_DEPTH; i++) begin
      drive_bytes(MIN_FRAME, 1'b0, 1'b1);
      model_commit(MIN_FRAME, i < HDR_DEPTH);
    end
    tick();
    n_cmp++; if (drop_count !== 16'(exp_drops)) begin n_bad++; $display("FAIL hdr_full drop_count: got %0d want %0d", drop_count, exp_drops); end
    tx_ready = 1'b1;
    wait_rx(HDR_DEPTH, 2000, ok);
    d = frames_diff();
    n_cmp++; if (!ok || d !== 0) begin n_bad++; $display("FAIL hdr_full frames: got %0d frames/%0d bytes want %0d/%0d", rxl.size(), rxb.size(), expl.size(), expb.size()); end
    n_cmp++; if (wr_free !== 13'(DEPTH)) begin n_bad++; $display("FAIL hdr_full wr_free: got %0d want %0d", wr_free, DEPTH); end
    clear_q();
  endtask

  task automatic test_link_down();
    bit ok;
    int d;
    tx_ready = 1'b0;
    drive_bytes(100, 1'b0, 1'b1);
    a_frame = frame;
    drive_bytes(60, 1'b0, 1'b1);
    tx_ready = 1'b1;
    repeat (31) tick();
    link_up = 1'b0;
    tick();
    drive_bytes(20, 1'b0, 1'b1);
    model_commit(20, 1'b1);
    link_up = 1'b1;
    repeat (300) tick();
    for (int i = 0; i < 30; i++) expb.push_back(a_frame[i]);
    expl.push_back(30);
    d = frames_diff();
    n_cmp++; if (d !== 0) begin n_bad++; $display("FAIL link_down truncation: got %0d frames/%0d bytes want %0d/%0d", rxl.size(), rxb.size(), expl.size(), expb.size()); end
    n_cmp++; if (drop_count !== 16'(exp_drops)) begin n_bad++; $display("FAIL link_down drop_count: got %0d want %0d", drop_count, exp_drops); end
    n_cmp++; if (wr_free !== 13'(DEPTH)) begin n_bad++; $display("FAIL link_down wr_free: got %0d want %0d", wr_free, DEPTH); end
    clear_q();
    drive_bytes(50, 1'b0, 1'b1);
    model_commit(50, 1'b1);
    wait_rx(1, 300, ok);
    d = frames_diff();
    n_cmp++; if (!ok || d !== 0) begin n_bad++; $display("FAIL link_down recovery: got %0d frames/%0d bytes want %0d/%0d", rxl.size(), rxb.size(), expl.size(), expb.size()); end
    clear_q();
  endtask

  task automatic test_reset_mid();
    tx_ready = 1'b1;
    drive_bytes(100, 1'b0, 1'b1);
    repeat (20) tick();
    drive_bytes(10, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    n_cmp++; if (tx_data_valid !== 1'b0 || tx_start !== 1'b0) begin n_bad++; $display("FAIL reset_mid tx: got start=%b valid=%b want 0/0", tx_start, tx_data_valid); end
    n_cmp++; if (wr_free !== 13'(DEPTH)) begin n_bad++; $display("FAIL reset_mid wr_free: got %0d want %0d", wr_free, DEPTH); end
    n_cmp++; if (drop_count !== 16'd0) begin n_bad++; $display("FAIL reset_mid drop_count: got %0d want 0", drop_count); end
    rst = 1'b0;
    exp_drops = 0;
    repeat (5) tick();
    clear_q();
  endtask

  task automatic test_wrap();
    bit ok;
    int d;
    tx_ready = 1'b1;
    for (int f = 0; f < 3; f++) begin
      drive_bytes(1300, 1'b0, 1'b1);
      model_commit(1300, 1'b1);
    end
    drive_bytes(200, 1'b0, 1'b1);
    model_commit(200, 1'b1);
    wait_rx(4, 8000, ok);
    d = frames_diff();
    n_cmp++; if (!ok || d !== 0) begin n_bad++; $display("FAIL wrap frames: got %0d frames/%0d bytes want %0d/%0d", rxl.size(), rxb.size(), expl.size(), expb.size()); end
    n_cmp++; if (wr_free !== 13'(DEPTH)) begin n_bad++; $display("FAIL wrap wr_free: got %0d want %0d", wr_free, DEPTH); end
    clear_q();
  endtask

  task automatic test_random();
    bit ok;
    int d, n, act, want;
    rnd_ready = 1'b1;
    for (int f = 0; f < 20; f++) begin
      n = $urandom_range(5, 200);
      act = $urandom_range(0, 3);
      if (act == 0) begin
        drive_bytes(n, 1'b0, 1'b1);
        model_commit(n, 1'b1);
      end else if (act == 1) begin
        drive_bytes(n, 1'b0, 1'b0);
        repeat ($urandom_range(0, 3)) tick();
        pulse(1'b1, 1'b0, 1'b0);
        model_commit(n, 1'b1);
      end else begin
        drive_bytes(n, 1'b0, 1'b0);
        pulse(act == 3, 1'b1, 1'b1);
      end
      repeat ($urandom_range(0, 5)) tick();
    end
    rnd_ready = 1'b0;
    tx_ready = 1'b1;
    want = expl.size();
    wait_rx(want, 8000, ok);
    d = frames_diff();
    n_cmp++; if (!ok || d !== 0) begin n_bad++; $display("FAIL random frames: got %0d frames/%0d bytes want %0d/%0d", rxl.size(), rxb.size(), expl.size(), expb.size()); end
    n_cmp++; if (drop_count !== 16'(exp_drops)) begin n_bad++; $display("FAIL random drop_count: got %0d want %0d", drop_count, exp_drops); end
    n_cmp++; if (wr_free !== 13'(DEPTH)) begin n_bad++; $display("FAIL random wr_free: got %0d want %0d", wr_free, DEPTH); end
    clear_q();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_filter();
    test_hdr_full();
    test_link_down();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
